// File: rtl/iob_cache_axi_refill.sv
// AXI4 read-burst line refill engine for a cache: one outstanding fill, INCR or
// critical-word-first WRAP bursts, beats streamed straight into the line RAM.
module iob_cache_axi_refill #(
  parameter int FE_ADDR_W  = 32,
  parameter int BE_DATA_W  = 32,
  parameter int LINE2MEM_W = 3,
  parameter int WRAP_EN    = 0,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ID     = 0,
  localparam int BE_BYTE_W = $clog2(BE_DATA_W / 8),
  localparam int BEATS     = 2 ** LINE2MEM_W,
  localparam int LW        = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          replace_valid,
  input  logic [FE_ADDR_W-BE_BYTE_W-1:0] replace_addr,
  output logic                          replace,
  output logic                          read_valid,
  output logic [LW-1:0]                 read_addr,
  output logic [BE_DATA_W-1:0]          read_rdata,
  output logic                          fill_err,
  output logic                          axi_arvalid,
  output logic [FE_ADDR_W-1:0]          axi_araddr,
  output logic [7:0]                    axi_arlen,
  output logic [2:0]                    axi_arsize,
  output logic [1:0]                    axi_arburst,
  output logic                          axi_arlock,
  output logic [3:0]                    axi_arcache,
  output logic [2:0]                    axi_arprot,
  output logic [3:0]                    axi_arqos,
  output logic [AXI_ID_W-1:0]           axi_arid,
  input  logic                          axi_arready,
  input  logic                          axi_rvalid,
  input  logic [BE_DATA_W-1:0]          axi_rdata,
  input  logic [1:0]                    axi_rresp,
  input  logic                          axi_rlast,
  output logic                          axi_rready
);

  localparam bit WE   = (WRAP_EN == 1) && (LINE2MEM_W >= 1) && (LINE2MEM_W <= 4);
  localparam int ZB   = WE ? BE_BYTE_W : LINE2MEM_W + BE_BYTE_W;
  localparam int NB_W = LINE2MEM_W + 1;
  localparam logic [FE_ADDR_W-1:0] AR_MASK = ~((FE_ADDR_W'(1) << ZB) - FE_ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                         state_reg;
  logic [FE_ADDR_W-BE_BYTE_W-1:0] addr_reg;
  logic [LW-1:0]                  cnt_reg;
  logic [NB_W-1:0]                nbeats_reg;
  logic                           replace_reg, arvalid_reg, rready_reg, fill_err_reg;
  logic [LW-1:0]                  cnt_inc, cnt_load;
  logic                           beat_ok;

  generate
    if (LINE2MEM_W == 0) begin : g_single
      assign cnt_inc  = '0;
      assign cnt_load = '0;
    end else begin : g_multi
      // LW-bit add wraps modulo BEATS on its own
      assign cnt_inc  = cnt_reg + LW'(1);
      assign cnt_load = WE ? addr_reg[LW-1:0] : '0;
    end
  endgenerate

  // Beats past a full line are acknowledged but never written
  assign beat_ok    = nbeats_reg < NB_W'(BEATS);
  assign read_valid = rready_reg & axi_rvalid & beat_ok;
  assign read_addr  = cnt_reg;
  assign read_rdata = axi_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      nbeats_reg   <= '0;
      replace_reg  <= 1'b0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
      fill_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (replace_valid) begin
          addr_reg     <= replace_addr;
          fill_err_reg <= 1'b0;
          replace_reg  <= 1'b1;
          arvalid_reg  <= 1'b1;
          state_reg    <= ADDR;
        end
        ADDR: if (axi_arready) begin
          arvalid_reg <= 1'b0;
          rready_reg  <= 1'b1;
          cnt_reg     <= cnt_load;
          nbeats_reg  <= '0;
          state_reg   <= DATA;
        end
        DATA: if (axi_rvalid) begin
          if (axi_rresp != 2'b00) fill_err_reg <= 1'b1;
          if (beat_ok) begin
            cnt_reg    <= cnt_inc;
            nbeats_reg <= nbeats_reg + NB_W'(1);
          end
          if (axi_rlast) begin
            rready_reg <= 1'b0;
            state_reg  <= DONE;
          end
        end
        default: begin
          replace_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign replace     = replace_reg;
  assign axi_arvalid = arvalid_reg;
  assign axi_rready  = rready_reg;
  assign fill_err    = fill_err_reg;
  assign axi_araddr  = {addr_reg, {BE_BYTE_W{1'b0}}} & AR_MASK;
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_arsize  = 3'(BE_BYTE_W);
  assign axi_arburst = WE ? 2'b10 : 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0011;
  assign axi_arprot  = 3'b010;
  assign axi_arqos   = 4'b0000;
  assign axi_arid    = AXI_ID_W'(AXI_ID);

endmodule
